serial_sub: RTL
===============

// Module: serial_sub
// PURPOSE
//  Bit-serial subtractor: the inverse-direction companion to the 4-bit ripple-carry adder.
//  - Computes a - b - b_in with one shared full-subtractor cell and a registered borrow.
//  - Processes one bit per clock, LSB first, behind a start/busy/done handshake.
//  - Sits beside the adder in the arithmetic datapath labs where area is traded for latency.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2)
// PORTS
//  clk    in   1      clock, all state on rising edge
//  rst    in   1      synchronous reset, active-high
//  start  in   1      request; sampled only while busy=0
//  a      in   WIDTH  minuend, latched when start accepted
//  b      in   WIDTH  subtrahend, latched when start accepted
//  b_in   in   1      borrow in, latched when start accepted
//  busy   out  1      high while a subtraction is in progress
//  done   out  1      one-cycle pulse: diff/b_out are valid
//  diff   out  WIDTH  (a - b - b_in) mod 2^WIDTH, held until next completion
//  b_out  out  1      borrow out: 1 iff a < b + b_in (unsigned)
// BEHAVIOUR
//  - Reset:
//    - state=IDLE; busy, done, diff, b_out all 0; bit counter and shift regs cleared.
//  - States IDLE, SHIFT, DONE.
//    - IDLE: start=1 -> latch a, b, b_in into shift regs/borrow FF; cnt=0; go SHIFT.
//    - SHIFT: each cycle:
//      - d_i = a_i ^ b_i ^ brw;
//      - brw <= (~a_i & b_i) | (~(a_i ^ b_i) & brw);
//      - shift d_i into result reg at MSB end; shift operands right; cnt++.
//      - At cnt=WIDTH-1 load diff/b_out from final values; go DONE.
//    - DONE: done=1 for exactly this cycle.
//      - start=1 here is accepted exactly as in IDLE (back-to-back ops); go SHIFT.
//      - Otherwise go IDLE.
//  - busy=1 exactly in SHIFT.
//  - Latency: start sampled at edge 0 -> done high in the cycle after edge WIDTH.
//    - Throughput: one op per WIDTH+1 cycles.
//  - start while busy=1: ignored, no effect on the operation in flight or on outputs.
//  - Operand inputs may change freely after the accepting edge.
//  - diff/b_out change only on the edge entering DONE (never mid-operation).
//  - rst mid-operation: abort immediately, all outputs to reset values, no done pulse.
//  - Counter width clog2(WIDTH); no wrap beyond WIDTH-1.
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined:
//    - Adds port ovf (out, 1): signed overflow = borrow into MSB ^ borrow out of MSB.
//    - Updated with diff; reset 0.
//  SERIAL_SUB_OVF_EN undefined:
//    - Port and logic absent; all other behaviour identical.
// TESTING
//  1 a=9,b=3,b_in=0 start -> done after 4 cycles, diff=6, b_out=0
//  2 a=3,b=5,b_in=0 -> diff=14, b_out=1; a=0,b=0,b_in=1 -> diff=15, b_out=1
//  3 OVF_EN: a=8,b=1,b_in=0 -> diff=7, b_out=0, ovf=1; a=5,b=2 -> ovf=0
//  4 start pulsed again at cycles 1-3 of an op -> ignored; result of first op only
//  5 start held high across done cycle -> second op accepted, next done 5 cycles later
//  6 rst at cycle 2 of op -> busy/done/diff/b_out=0 next cycle, no done pulse; WIDTH=8 255-1=254

Source files
------------

// File: rtl/serial_sub_if.sv
// Handshake/operand bundle for the bit-serial subtractor.
// SERIAL_SUB_OVF_EN adds the signed-overflow output to the bundle.
interface serial_sub_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, b_in, input busy, done, diff, b_out, ovf);
  modport slave  (input start, a, b, b_in, output busy, done, diff, b_out, ovf);
`else
  modport master (output start, a, b, b_in, input busy, done, diff, b_out);
  modport slave  (input start, a, b, b_in, output busy, done, diff, b_out);
`endif
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b - b_in, one bit per clock LSB first, start/busy/done handshake.
// Optional SERIAL_SUB_OVF_EN adds a registered signed-overflow flag.
module serial_sub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RES_W = WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               brw_q, brw_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic               accept;
  logic               d_bit;
  logic               brw_nxt;

  // Shared full-subtractor cell working on the current LSBs.
  assign d_bit   = a_q[0] ^ b_q[0] ^ brw_q;
  assign brw_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    accept  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) accept = 1'b1;
      end
      S_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = brw_nxt;
        res_d = RES_W'({d_bit, res_q} >> 1);
        cnt_d = cnt_q + CNT_W'(1);
        // Final bit: publish the result and the borrow leaving the MSB.
        if (cnt_q == CNT_LAST) begin
          diff_d  = {d_bit, res_q};
          bout_d  = brw_nxt;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = brw_q ^ brw_nxt;
`endif
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) accept = 1'b1;
        else           state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      brw_d   = bus.b_in;
      res_d   = '0;
      cnt_d   = '0;
      state_d = S_SHIFT;
    end

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.b_out = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule
